// File: rtl/ps2_key_event_encoder.sv
// ps2_key_event_encoder
// Turns a raw PS/2 set-2 scancode byte stream (make, E0 extended, F0 break, E1 pause)
// into 11-bit key events on ps2_key. Each event flips ps2_key[10], so consumers only
// have to edge-detect that bit.
//
// Optional feature macro: PS2_PAUSE_EN
//   defined   : E1 14 77 E1 F0 14 F0 77 is matched byte for byte and yields one
//               event {pressed=1, ext=1, code=8'h77}; a mismatch raises proto_err.
//   undefined : E1 and the seven bytes after it are swallowed with no event and no error.
//
// Ports
//   clk_sys     in   1   system clock, posedge
//   RESET_N     in   1   asynchronous active-low reset
//   byte_in     in   8   scancode byte from the PS/2 receiver
//   byte_valid  in   1   byte_in valid, held until accepted
//   byte_ready  out  1   byte accepted when byte_valid & byte_ready
//   ps2_key     out  11  [10] toggle, [9] pressed, [8] extended, [7:0] code
//   key_strobe  out  1   one-cycle pulse in the cycle ps2_key updates
//   proto_err   out  1   one-cycle pulse on prefix timeout or illegal sequence
module ps2_key_event_encoder #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [10:0] ps2_key,
    output logic        key_strobe,
    output logic        proto_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Expiry fires on the TIMEOUT_CYCLES-th idle cycle spent waiting for a follower byte.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef PS2_PAUSE_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_EMIT    = 3'd4,
        ST_PAUSE   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_EMIT    = 3'd4,
        ST_SKIP    = 3'd5
    } state_t;
`endif

    state_t           state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic [2:0]       idx_r, idx_next_s;
    logic             byte_ready_r, key_strobe_r, proto_err_r;
    logic [10:0]      ps2_key_r;
    logic             accept_s, emit_s, err_s, waiting_s;
    logic [9:0]       emit_key_s;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
    endfunction

    // Keyboard housekeeping replies (BAT ok, ACK, resend, echo, overruns) carry no key.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
               (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

`ifdef PS2_PAUSE_EN
    // Bytes expected after the leading E1 of the Pause sequence.
    function automatic logic [7:0] pause_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h14;
            3'd1:    return 8'h77;
            3'd2:    return 8'hE1;
            3'd3:    return 8'hF0;
            3'd4:    return 8'h14;
            3'd5:    return 8'hF0;
            3'd6:    return 8'h77;
            default: return 8'h00;
        endcase
    endfunction
`endif

    assign accept_s = byte_valid & byte_ready_r;

    // Next-state, event decode and prefix timeout.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        idx_next_s   = idx_r;
        emit_s       = 1'b0;
        emit_key_s   = ps2_key_r[9:0];
        err_s        = 1'b0;
        waiting_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (byte_in == 8'hE0) begin
                        state_next_s = ST_EXT;
                    end else if (byte_in == 8'hF0) begin
                        state_next_s = ST_BRK;
                    end else if (byte_in == 8'hE1) begin
                        idx_next_s = 3'd0;
`ifdef PS2_PAUSE_EN
                        state_next_s = ST_PAUSE;
`else
                        state_next_s = ST_SKIP;
`endif
                    end else if (is_discard(byte_in)) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        emit_s     = 1'b1;
                        emit_key_s = {1'b1, 1'b0, byte_in};
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXT: begin
                waiting_s = 1'b1;
                if (accept_s) begin
                    if (byte_in == 8'hF0) begin
                        state_next_s = ST_EXT_BRK;
                    end else if (byte_in == 8'hE0) begin
                        state_next_s = ST_EXT;
                    end else begin
                        emit_s     = 1'b1;
                        emit_key_s = {1'b1, 1'b1, byte_in};
                    end
                end else begin
                    state_next_s = ST_EXT;
                end
            end
            ST_BRK: begin
                waiting_s = 1'b1;
                if (accept_s) begin
                    if (is_prefix(byte_in)) begin
                        err_s        = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        emit_s     = 1'b1;
                        emit_key_s = {1'b0, 1'b0, byte_in};
                    end
                end else begin
                    state_next_s = ST_BRK;
                end
            end
            ST_EXT_BRK: begin
                waiting_s = 1'b1;
                if (accept_s) begin
                    if (is_prefix(byte_in)) begin
                        err_s        = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        emit_s     = 1'b1;
                        emit_key_s = {1'b0, 1'b1, byte_in};
                    end
                end else begin
                    state_next_s = ST_EXT_BRK;
                end
            end
`ifdef PS2_PAUSE_EN
            ST_PAUSE: begin
                waiting_s = 1'b1;
                if (accept_s) begin
                    if (byte_in != pause_byte(idx_r)) begin
                        err_s        = 1'b1;
                        state_next_s = ST_IDLE;
                    end else if (idx_r == 3'd6) begin
                        emit_s     = 1'b1;
                        emit_key_s = {1'b1, 1'b1, 8'h77};
                    end else begin
                        idx_next_s = idx_r + 3'd1;
                    end
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
`else
            ST_SKIP: begin
                waiting_s = 1'b1;
                if (accept_s) begin
                    if (idx_r == 3'd6) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        idx_next_s = idx_r + 3'd1;
                    end
                end else begin
                    state_next_s = ST_SKIP;
                end
            end
`endif
            ST_EMIT: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        if (emit_s) begin
            state_next_s = ST_EMIT;
        end else begin
            state_next_s = state_next_s;
        end

        // An accepted byte always beats expiry in the same cycle.
        if (accept_s) begin
            cnt_next_s = '0;
        end else if (waiting_s && (TIMEOUT_CYCLES != 0)) begin
            if (cnt_r == CNT_LAST) begin
                err_s        = 1'b1;
                state_next_s = ST_IDLE;
                cnt_next_s   = '0;
            end else begin
                cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_next_s = '0;
        end
    end

    // State, counters and registered outputs; outputs reflect the state being entered.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            idx_r        <= 3'd0;
            byte_ready_r <= 1'b0;
            ps2_key_r    <= 11'h000;
            key_strobe_r <= 1'b0;
            proto_err_r  <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            idx_r        <= idx_next_s;
            byte_ready_r <= (state_next_s != ST_EMIT);
            key_strobe_r <= emit_s;
            proto_err_r  <= err_s;
            if (emit_s) begin
                ps2_key_r <= {~ps2_key_r[10], emit_key_s};
            end else begin
                ps2_key_r <= ps2_key_r;
            end
        end
    end

    assign byte_ready = byte_ready_r;
    assign ps2_key    = ps2_key_r;
    assign key_strobe = key_strobe_r;
    assign proto_err  = proto_err_r;

endmodule

// File: tb/tb_ps2_key_event_encoder.sv
// Scoreboard bench for ps2_key_event_encoder: stimulus pushes expected events/errors,
// a negedge monitor pops and compares whenever key_strobe or proto_err is seen.
module tb_ps2_key_event_encoder;

    localparam int unsigned TO = 16;

    logic        clk_sys = 1'b0;
    logic        RESET_N;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [10:0] ps2_key;
    logic        key_strobe;
    logic        proto_err;

    typedef struct packed {
        logic        is_err;
        logic [10:0] key;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [10:0] last_key_m;
    int          checks = 0;
    int          errors = 0;

    always #5 clk_sys = ~clk_sys;

    ps2_key_event_encoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_sys    (clk_sys),
        .RESET_N    (RESET_N),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .ps2_key    (ps2_key),
        .key_strobe (key_strobe),
        .proto_err  (proto_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_key(input logic tog, input logic pressed, input logic ext, input logic [7:0] code);
        exp_t e;
        e.is_err = 1'b0;
        e.key    = {tog, pressed, ext, code};
        last_key_m = e.key;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.key    = 11'h000;
        exp_q.push_back(e);
    endtask

    // Presents one byte and returns just after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && waited < 20) begin
            @(negedge clk_sys);
            waited++;
        end
        if (byte_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_wait: byte %h not accepted within 20 cycles", b);
            byte_valid = 1'b0;
        end else begin
            @(posedge clk_sys);
            #1;
            byte_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk_sys) begin
        if (key_strobe === 1'b1 || proto_err === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: key_strobe=%b proto_err=%b ps2_key=%h expected none",
                         key_strobe, proto_err, ps2_key);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_err) begin
                    check("proto_err_pulse", {30'd0, proto_err, key_strobe}, 32'h2);
                end else begin
                    check("ps2_key", {21'd0, ps2_key}, {21'd0, mon_e.key});
                    check("strobe_ready_proto", {29'd0, key_strobe, byte_ready, proto_err}, 32'h4);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N    = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        last_key_m = 11'h000;
        idle(3);
        check("reset_key",   {21'd0, ps2_key}, 32'h0);
        check("reset_ready", {31'd0, byte_ready}, 32'h0);
        check("reset_pulse", {30'd0, key_strobe, proto_err}, 32'h0);
        @(negedge clk_sys);
        RESET_N = 1'b1;
        #1;
        check("ready_before_edge", {31'd0, byte_ready}, 32'h0);
        idle(1);
        check("ready_after_release", {31'd0, byte_ready}, 32'h1);

        // Plain make, then break of the same key.
        send_byte(8'h1C);                     expect_key(1'b1, 1'b1, 1'b0, 8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);   expect_key(1'b0, 1'b0, 1'b0, 8'h1C);
        // Extended make and break.
        send_byte(8'hE0); send_byte(8'h75);   expect_key(1'b1, 1'b1, 1'b1, 8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        expect_key(1'b0, 1'b0, 1'b1, 8'h75);
        // Prefix timeout, then a fresh non-extended make.
        send_byte(8'hE0); expect_err(); idle(TO + 4);
        send_byte(8'h29);                     expect_key(1'b1, 1'b1, 1'b0, 8'h29);
        // Housekeeping bytes are silent.
        send_byte(8'hAA); send_byte(8'hFA); send_byte(8'hEE); send_byte(8'h00); send_byte(8'hFF);
        // Prefix after F0 is illegal; repeated E0 is tolerated.
        send_byte(8'hF0); send_byte(8'hE0);   expect_err();
        send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h75);
        expect_key(1'b0, 1'b1, 1'b1, 8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'hE1);
        expect_err();
        // Back-to-back makes with valid held.
        send_byte(8'h1C);                     expect_key(1'b1, 1'b1, 1'b0, 8'h1C);
        send_byte(8'h1C);                     expect_key(1'b0, 1'b1, 1'b0, 8'h1C);
        // Pause sequence, followed by a make to show parsing resumes cleanly.
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
`ifdef PS2_PAUSE_EN
        expect_key(1'b1, 1'b1, 1'b1, 8'h77);
        send_byte(8'h1C);                     expect_key(1'b0, 1'b1, 1'b0, 8'h1C);
`else
        send_byte(8'h1C);                     expect_key(1'b1, 1'b1, 1'b0, 8'h1C);
`endif
        idle(5);
        check("key_hold", {21'd0, ps2_key}, {21'd0, last_key_m});

        // Reset in the middle of a break sequence.
        send_byte(8'hF0);
        idle(2);
        RESET_N = 1'b0;
        #1;
        check("midreset_key",   {21'd0, ps2_key}, 32'h0);
        check("midreset_ready", {31'd0, byte_ready}, 32'h0);
        @(negedge clk_sys);
        RESET_N = 1'b1;
        idle(1);
        send_byte(8'h1C);                     expect_key(1'b1, 1'b1, 1'b0, 8'h1C);
        idle(5);
        check("scoreboard_drained", exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
